// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared encodings for the pattern scan controller and its serial 010111 detector.
package pattern_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // Detector states: the name is the length of the pattern prefix matched so far.
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;

    localparam int PATTERN_LEN = 6;

endpackage

// File: rtl/pattern_scan_ctrl_seq_det.sv
// Moore detector for the serial pattern 010111; hit is asserted while in S6.
module seq_det
    import pattern_scan_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clock) begin
        if (reset || clear) state <= S0;
        else if (en)        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S0;
        case (state)
            S0:      state_nxt = bit_in ? S0 : S1;
            S1:      state_nxt = bit_in ? S2 : S1;
            S2:      state_nxt = bit_in ? S0 : S3;
            S3:      state_nxt = bit_in ? S4 : S1;
            S4:      state_nxt = bit_in ? S5 : S3;
            S5:      state_nxt = bit_in ? S6 : S1;
            S6:      state_nxt = bit_in ? S0 : S1;
            default: state_nxt = S0;
        endcase
    end

    assign hit = (state == S6);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Round-robin front end that serializes a requester's word into the shared
// detector and reports the saturating hit count with a one-cycle done pulse.
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic             match_any
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    ctrl_state_e      state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [CNT_W-1:0] work_cnt, cnt_inc;
    logic             favor;
    logic             grant_id;
    logic             cur_id;
    logic             det_clear, det_en, det_hit;

    // favor names the requester that wins a tie; it flips away from each grantee.
    always_comb begin
        grant_id = req[1];
        if (req == 2'b11) grant_id = favor;
    end

    assign cnt_inc = (det_hit && (work_cnt != '1)) ? work_cnt + CNT_W'(1) : work_cnt;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        det_clear = 1'b0;
        det_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_SHIFT;
                    det_clear = 1'b1;
                end
            end
            ST_SHIFT: begin
                det_en = 1'b1;
                if (bit_cnt == LAST_BIT) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            favor     <= 1'b0;
            cur_id    <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
            work_cnt  <= '0;
            ack       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            match_cnt <= '0;
            match_any <= 1'b0;
        end else begin
            ack  <= 2'b00;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        ack      <= grant_id ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        favor    <= ~grant_id;
                        cur_id   <= grant_id;
                        sreg     <= grant_id ? data1 : data0;
                        bit_cnt  <= '0;
                        work_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    sreg     <= {sreg[WIDTH-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + BC_W'(1);
                    work_cnt <= cnt_inc;
                end
                // Final count includes a hit produced by the last shifted bit.
                ST_FLUSH: begin
                    work_cnt  <= cnt_inc;
                    done      <= 1'b1;
                    done_id   <= cur_id;
                    match_cnt <= cnt_inc;
                    match_any <= (cnt_inc != '0);
                end
                ST_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    seq_det u_det (
        .clock  (clock),
        .reset  (reset),
        .clear  (det_clear),
        .en     (det_en),
        .bit_in (sreg[WIDTH-1]),
        .hit    (det_hit)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench: drivers push expected completions, negedge monitors pop on done.
module tb_pattern_scan_ctrl;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]   req;
    logic [W-1:0] data0, data1;
    logic [1:0]   ack;
    logic         busy, done, done_id, match_any;
    logic [3:0]   match_cnt;

    logic [1:0]  req_s;
    logic [15:0] sd;
    logic [1:0]  ack_s1, ack_s2;
    logic        busy_s1, busy_s2, done_s1, done_s2, id_s1, id_s2, any_s1, any_s2;
    logic [0:0]  cnt_s1;
    logic [1:0]  cnt_s2;

    pattern_scan_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .match_any(match_any)
    );

    pattern_scan_ctrl #(.WIDTH(16), .CNT_W(1)) dut_s1 (
        .clock(clock), .reset(reset), .req(req_s), .data0(sd), .data1(16'h0000),
        .ack(ack_s1), .busy(busy_s1), .done(done_s1), .done_id(id_s1),
        .match_cnt(cnt_s1), .match_any(any_s1)
    );

    pattern_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut_s2 (
        .clock(clock), .reset(reset), .req(req_s), .data0(sd), .data1(16'h0000),
        .ack(ack_s2), .busy(busy_s2), .done(done_s2), .done_id(id_s2),
        .match_cnt(cnt_s2), .match_any(any_s2)
    );

    typedef struct {
        logic id;
        int   cnt;
        int   at;
    } exp_t;

    exp_t q[$];
    int   qs1[$];
    int   qs2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("done_id", int'(done_id), int'(e.id));
                chk("match_cnt", int'(match_cnt), e.cnt);
                chk("match_any", int'(match_any), int'(e.cnt != 0));
                chk("done_cycle", cyc, e.at);
            end
        end
        if (done_s1 === 1'b1) begin
            if (qs1.size() == 0) chk("unexpected_done_s1", 1, 0);
            else chk("sat_cnt_w1", int'(cnt_s1), qs1.pop_front());
        end
        if (done_s2 === 1'b1) begin
            if (qs2.size() == 0) chk("unexpected_done_s2", 1, 0);
            else chk("sat_cnt_w2", int'(cnt_s2), qs2.pop_front());
        end
    end

    // Waits (bounded) for the next ack on the main instance, starting one negedge later.
    task automatic wait_ack(output int a_cyc, output logic [1:0] a_val);
        int n = 0;
        @(negedge clock);
        while (ack == 2'b00 && n < 40) begin
            @(negedge clock);
            n++;
        end
        a_val = ack;
        a_cyc = cyc;
        if (ack == 2'b00) chk("ack_timeout", 0, 1);
    endtask

    // Single-requester job on an idle controller; also checks ack/busy timing.
    task automatic job(input logic [1:0] r, input logic [W-1:0] d, input int expcnt);
        int a, start;
        logic [1:0] av;
        exp_t e;
        @(negedge clock);
        req = r;
        if (r[0]) data0 = d;
        else      data1 = d;
        start = cyc;
        wait_ack(a, av);
        req = 2'b00;
        chk("ack_val", int'(av), int'(r));
        chk("ack_latency", a - start, 1);
        chk("busy_rise", int'(busy), 1);
        e.id = r[1]; e.cnt = expcnt; e.at = a + W + 1;
        q.push_back(e);
        repeat (W + 1) @(negedge clock);
        chk("busy_in_done", int'(busy), 1);
        @(negedge clock);
        chk("busy_fall", int'(busy), 0);
    endtask

    initial begin
        int a1, a2, n;
        logic [1:0] v1, v2;
        exp_t e;
        reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0; req_s = 2'b00; sd = '0;
        repeat (3) @(negedge clock);
        chk("reset_outs", int'({ack, busy, done, done_id, match_cnt, match_any}), 0);
        reset = 1'b0;

        // Both requesting right after reset: 0 first, then 1 eleven cycles later.
        req = 2'b11; data0 = 8'h5C; data1 = 8'h00;
        wait_ack(a1, v1);
        req[0] = 1'b0;
        chk("arb_first", int'(v1), 1);
        e.id = 1'b0; e.cnt = 1; e.at = a1 + W + 1; q.push_back(e);
        wait_ack(a2, v2);
        req[1] = 1'b0;
        chk("arb_second", int'(v2), 2);
        chk("arb_spacing", a2 - a1, 11);
        e.id = 1'b1; e.cnt = 0; e.at = a2 + W + 1; q.push_back(e);
        repeat (10) @(negedge clock);

        req = 2'b11; data0 = 8'h17; data1 = 8'h5C;
        wait_ack(a1, v1);
        req[0] = 1'b0;
        chk("arb_third", int'(v1), 1);
        e.id = 1'b0; e.cnt = 1; e.at = a1 + W + 1; q.push_back(e);
        wait_ack(a2, v2);
        req[1] = 1'b0;
        chk("arb_fourth", int'(v2), 2);
        e.id = 1'b1; e.cnt = 1; e.at = a2 + W + 1; q.push_back(e);
        repeat (10) @(negedge clock);

        job(2'b01, 8'h5C, 1);
        job(2'b10, 8'h00, 0);
        job(2'b01, 8'h17, 1);
        job(2'b10, 8'hFF, 0);

        // Reset during SHIFT abandons the job: no done may follow.
        @(negedge clock);
        req = 2'b01; data0 = 8'h5C;
        wait_ack(a1, v1);
        req = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_outs", int'({ack, busy, done, done_id, match_cnt, match_any}), 0);
        repeat (14) @(negedge clock);

        // Reset coinciding with req wins; the grant happens only once reset drops.
        reset = 1'b1; req = 2'b01; data0 = 8'h5C;
        @(negedge clock);
        chk("reset_vs_req", int'({ack, busy}), 0);
        reset = 1'b0;
        wait_ack(a1, v1);
        req = 2'b00;
        chk("post_reset_ack", int'(v1), 1);
        e.id = 1'b0; e.cnt = 1; e.at = a1 + W + 1; q.push_back(e);
        repeat (11) @(negedge clock);

        // 16-bit word with two raw hits, counted into 1- and 2-bit counters.
        req_s = 2'b01; sd = 16'h5C5C;
        n = 0;
        @(negedge clock);
        while (ack_s1 == 2'b00 && n < 40) begin
            @(negedge clock);
            n++;
        end
        req_s = 2'b00;
        chk("sat_ack", int'(ack_s1 | ack_s2), 1);
        qs1.push_back(1);
        qs2.push_back(2);
        repeat (22) @(negedge clock);

        chk("scoreboard_empty", q.size() + qs1.size() + qs2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
